// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch stage. Holds the fetch PC, issues one word
//            request at a time to instruction memory (req/gnt/rvalid), buffers
//            tagged responses in a small queue and presents
//            {instruction, pc, pc+4} with a valid flag to the IF/ID register.
// Ports    : clk, rst (sync, active-high)
//            en                     - IF/ID enable, head consumed on valid&&en
//            redirect, redirect_pc  - flush queue and refetch from new PC
//            imem_req, imem_addr    - memory request
//            imem_gnt               - request accepted
//            imem_rvalid, imem_rdata- in-order memory response
//            valid_out, ins_out, pc_out, pc_plus4_out - head entry
// Options  : IF_FETCH_BYPASS_EN - when defined, a response arriving with an
//            empty queue is forwarded combinationally to the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter int                  DATA_LENGTH = 32,
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [DATA_LENGTH-1:0] imem_rdata,
    output logic                   valid_out,
    output logic [DATA_LENGTH-1:0] ins_out,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [PC_WIDTH-1:0]    pc_plus4_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_LENGTH-1:0] c_NOP     = DATA_LENGTH'(32'h0000_0013);
    localparam logic [PC_WIDTH-1:0]    c_PC_STEP = PC_WIDTH'(4);
    localparam logic [CW:0]            c_DEPTH   = (CW+1)'(FIFO_DEPTH);

    logic [PC_WIDTH-1:0]    r_fetch_pc;
    logic [PC_WIDTH-1:0]    r_tag;          // PC of the outstanding request
    logic                   r_outstanding;
    logic                   r_drop;         // stale response still to come
    logic [DATA_LENGTH-1:0] r_q_ins [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]    r_q_pc  [FIFO_DEPTH];
    logic [CW-1:0]          r_count;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;

    logic                   w_resp;
    logic                   w_resp_live;
    logic                   w_q_empty;
    logic                   w_bypass;
    logic                   w_valid;
    logic                   w_pop;
    logic                   w_q_pop;
    logic                   w_push;
    logic [CW:0]            w_occ;
    logic                   w_issue;
    logic                   w_gnt;
    logic [DATA_LENGTH-1:0] w_head_ins;
    logic [PC_WIDTH-1:0]    w_head_pc;
    logic                   w_unused_rpc;

    // Low address bits of the redirect target are never used.
    assign w_unused_rpc = ^redirect_pc[1:0];

    // A response only counts when a request is actually outstanding; anything
    // arriving after a reset is ignored.
    assign w_resp      = imem_rvalid && r_outstanding;
    assign w_resp_live = w_resp && !r_drop && !redirect;
    assign w_q_empty   = (r_count == '0);

`ifdef IF_FETCH_BYPASS_EN
    assign w_bypass = w_resp_live && w_q_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_valid = !w_q_empty || w_bypass;
    assign w_pop   = w_valid && en;
    assign w_q_pop = w_pop && !w_q_empty && !redirect;
    // A bypassed response that is consumed immediately never enters the queue.
    assign w_push  = w_resp_live && !(w_bypass && en);

    // Slots committed after this cycle: stored entries plus the in-flight
    // request, less the entry leaving now. A new request needs a free slot.
    assign w_occ   = {1'b0, r_count} + (CW+1)'(r_outstanding) - (CW+1)'(w_pop);
    assign w_issue = !rst && !redirect && !r_drop
                     && (!r_outstanding || imem_rvalid)
                     && (w_occ < c_DEPTH);
    assign w_gnt   = w_issue && imem_gnt;

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;

    assign w_head_ins = w_q_empty ? imem_rdata : r_q_ins[r_rd_ptr];
    assign w_head_pc  = w_q_empty ? r_tag      : r_q_pc[r_rd_ptr];

    assign valid_out    = w_valid;
    assign ins_out      = w_valid ? w_head_ins : c_NOP;
    assign pc_out       = w_valid ? w_head_pc : '0;
    assign pc_plus4_out = w_valid ? (w_head_pc + c_PC_STEP) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_tag         <= '0;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            // Grant and redirect are exclusive: req is held low on redirect.
            if (w_gnt) begin
                r_outstanding <= 1'b1;
                r_tag         <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + c_PC_STEP;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
            end

            if (redirect) begin
                r_fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
                r_drop     <= r_outstanding && !imem_rvalid;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_resp && r_drop) begin
                    r_drop <= 1'b0;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_q_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_q_pop);
            end
        end
    end

    // Queue storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_q_ins[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]  <= r_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Self-checking bench for if_fetch. A cycle table drives the main
//            stream / back-pressure / redirect scenario; hand-written
//            sequences cover late-response redirect, reset mid-flight,
//            PC wrap and the same-cycle bypass path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_out;
    logic [31:0] ins_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;

    int n_cmp = 0;
    int n_err = 0;

    // Memory model: responds lat cycles after grant.
    logic        gnt_en = 1'b1;
    int          lat = 1;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;

    always #5 clk = ~clk;

    if_fetch #(
        .DATA_LENGTH(32),
        .PC_WIDTH   (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .valid_out   (valid_out),
        .ins_out     (ins_out),
        .pc_out      (pc_out),
        .pc_plus4_out(pc_plus4_out)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h40) return 32'h0050_0093;
        return a ^ 32'h5A00_0013;
    endfunction

    assign imem_gnt    = gnt_en;
    assign imem_rvalid = (m_cnt == 1);
    assign imem_rdata  = memf(m_addr);

    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            m_cnt  <= lat;
            m_addr <= imem_addr;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge with
    // rst released, i.e. in the first cycle out of reset.
    task automatic do_reset();
        rst = 1'b1; en = 1'b1; redirect = 1'b0; gnt_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.valid", {31'b0, valid_out}, 32'd0);
        chk("rst.req",   {31'b0, imem_req},  32'd0);
        chk("rst.ins",   ins_out,            32'h13);
        chk("rst.pc",    pc_out,             32'd0);
        chk("rst.pc4",   pc_plus4_out,       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where valid_out is high.
    task automatic wait_valid(input string nm);
        int k = 0;
        while (!valid_out && k < 12) begin
            @(posedge clk); #1;
            @(negedge clk);
            k++;
        end
        chk({nm, ".wait"}, {31'b0, valid_out}, 32'd1);
    endtask

    typedef struct {
        logic        en;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic r, input logic [31:0] rp,
                                input logic v, input logic [31:0] p,
                                input logic q, input logic [31:0] a);
        vec_t t;
        t.en = e; t.redir = r; t.rpc = rp;
        t.exp_valid = v; t.exp_pc = p; t.exp_req = q; t.exp_addr = a;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[18];
        logic [31:0] e_ins;
        logic [31:0] e_pc4;

        lat = 1;
        do_reset();

`ifndef IF_FETCH_BYPASS_EN
        // Stream, 5-cycle stall, release, redirect with pop + arriving response.
        vt[0]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h0);
        vt[1]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h4);
        vt[2]  = mk(1, 0, 32'h0,   1, 32'h0,   1, 32'h8);
        vt[3]  = mk(1, 0, 32'h0,   1, 32'h4,   1, 32'hC);
        vt[4]  = mk(0, 0, 32'h0,   1, 32'h8,   0, 32'h0);
        vt[5]  = mk(0, 0, 32'h0,   1, 32'h8,   0, 32'h0);
        vt[6]  = mk(0, 0, 32'h0,   1, 32'h8,   0, 32'h0);
        vt[7]  = mk(0, 0, 32'h0,   1, 32'h8,   0, 32'h0);
        vt[8]  = mk(0, 0, 32'h0,   1, 32'h8,   0, 32'h0);
        vt[9]  = mk(1, 0, 32'h0,   1, 32'h8,   1, 32'h10);
        vt[10] = mk(1, 0, 32'h0,   1, 32'hC,   1, 32'h14);
        vt[11] = mk(1, 0, 32'h0,   1, 32'h10,  1, 32'h18);
        vt[12] = mk(1, 0, 32'h0,   1, 32'h14,  1, 32'h1C);
        vt[13] = mk(1, 1, 32'h103, 1, 32'h18,  0, 32'h0);
        vt[14] = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h100);
        vt[15] = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h104);
        vt[16] = mk(1, 0, 32'h0,   1, 32'h100, 1, 32'h108);
        vt[17] = mk(1, 0, 32'h0,   1, 32'h104, 1, 32'h10C);

        for (int i = 0; i < 18; i++) begin
            en = vt[i].en; redirect = vt[i].redir; redirect_pc = vt[i].rpc;
            @(negedge clk);
            e_ins = vt[i].exp_valid ? memf(vt[i].exp_pc) : 32'h13;
            e_pc4 = vt[i].exp_valid ? vt[i].exp_pc + 32'd4 : 32'd0;
            chk($sformatf("v%0d.valid", i), {31'b0, valid_out}, {31'b0, vt[i].exp_valid});
            chk($sformatf("v%0d.pc", i), pc_out, vt[i].exp_pc);
            chk($sformatf("v%0d.pc4", i), pc_plus4_out, e_pc4);
            chk($sformatf("v%0d.ins", i), ins_out, e_ins);
            chk($sformatf("v%0d.req", i), {31'b0, imem_req}, {31'b0, vt[i].exp_req});
            if (vt[i].exp_req) chk($sformatf("v%0d.addr", i), imem_addr, vt[i].exp_addr);
            @(posedge clk); #1;
        end
        redirect = 1'b0; en = 1'b1;
`endif

        // Redirect while a slow response is in flight: stale data dropped.
        lat = 3;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h10;
        @(negedge clk); chk("lr.req_redir0", {31'b0, imem_req}, 32'd0);
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk); chk("lr.req10", {31'b0, imem_req}, 32'd1);
        chk("lr.addr10", imem_addr, 32'h10);
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk); chk("lr.req_redir1", {31'b0, imem_req}, 32'd0);
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk); chk("lr.req_drop1", {31'b0, imem_req}, 32'd0);
        chk("lr.valid_drop1", {31'b0, valid_out}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("lr.req_stale", {31'b0, imem_req}, 32'd0);
        chk("lr.valid_stale", {31'b0, valid_out}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("lr.req200", {31'b0, imem_req}, 32'd1);
        chk("lr.addr200", imem_addr, 32'h200);
        chk("lr.valid_pre", {31'b0, valid_out}, 32'd0);
        wait_valid("lr");
        chk("lr.pc", pc_out, 32'h200);
        chk("lr.ins", ins_out, memf(32'h200));

        // Reset with a response still in flight; it must not be pushed.
        @(posedge clk); #1; rst = 1'b1; gnt_en = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mr%0d.valid", i), {31'b0, valid_out}, 32'd0);
            chk($sformatf("mr%0d.req", i), {31'b0, imem_req}, 32'd1);
            chk($sformatf("mr%0d.addr", i), imem_addr, 32'h0);
            @(posedge clk); #1;
        end
        lat = 1; gnt_en = 1'b1;
        @(negedge clk);
        wait_valid("mr");
        chk("mr.pc", pc_out, 32'h0);
        @(posedge clk); #1;

        // PC wrap at the top of the address space.
        lat = 1;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk); chk("wr.req_redir", {31'b0, imem_req}, 32'd0);
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk); chk("wr.addr_top", imem_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        @(negedge clk); chk("wr.addr_wrap", imem_addr, 32'h0);
        chk("wr.req_wrap", {31'b0, imem_req}, 32'd1);
        wait_valid("wr");
        chk("wr.pc_top", pc_out, 32'hFFFF_FFFC);
        chk("wr.pc4_top", pc_plus4_out, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wr.pc_zero", pc_out, 32'h0);
        chk("wr.pc4_zero", pc_plus4_out, 32'h4);
        @(posedge clk); #1;

        // Response into an empty queue: same-cycle with bypass, else next cycle.
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk); chk("bp.addr", imem_addr, 32'h40);
        @(posedge clk); #1;
        @(negedge clk);
`ifdef IF_FETCH_BYPASS_EN
        chk("bp.valid_now", {31'b0, valid_out}, 32'd1);
        chk("bp.ins_now", ins_out, 32'h0050_0093);
        chk("bp.pc_now", pc_out, 32'h40);
`else
        chk("bp.valid_now", {31'b0, valid_out}, 32'd0);
        chk("bp.ins_now", ins_out, 32'h13);
`endif
        @(posedge clk); #1;
        @(negedge clk);
`ifdef IF_FETCH_BYPASS_EN
        chk("bp.valid_next", {31'b0, valid_out}, 32'd1);
        chk("bp.pc_next", pc_out, 32'h44);
`else
        chk("bp.valid_next", {31'b0, valid_out}, 32'd1);
        chk("bp.pc_next", pc_out, 32'h40);
        chk("bp.ins_next", ins_out, 32'h0050_0093);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage RISC-V pipeline. Holds the fetch PC and issues word requests to instruction memory over a request/grant/response handshake. Buffers returned instructions in a small tagged queue. Presents `{instruction, pc, pc+4}` with a valid flag to the IF/ID pipeline register, honouring that register's enable as back-pressure and the execute stage's redirect as a flush.

## Interface
- `DATA_LENGTH`, 32: instruction width.
- `PC_WIDTH`, 32: PC width.
- `RESET_PC`, 0: fetch address after reset.
- `FIFO_DEPTH`, 2: fetch-queue entries, power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  downstream IF/ID enable; head entry consumed when `valid_out && en`.
- `redirect`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  PC_WIDTH  new fetch address, valid with `redirect`.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  PC_WIDTH  request word address.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid.
- `imem_rdata`  in  DATA_LENGTH  response instruction.
- `valid_out`  out  1  head entry valid.
- `ins_out`  out  DATA_LENGTH  head instruction; 32'h00000013 (NOP) when `valid_out`=0.
- `pc_out`  out  PC_WIDTH  head PC; 0 when invalid.
- `pc_plus4_out`  out  PC_WIDTH  head PC+4; 0 when invalid.

## Operation
- State: `fetch_pc`; `outstanding` (0/1); `drop` flag; queue of `{ins, pc}` with `count`, read/write pointers.
- At most one outstanding request. Responses arrive in order, ≥1 cycle after grant.
- Issue condition (combinational): `!rst && !redirect && !drop_blocking && (outstanding==0 || imem_rvalid) && (count + outstanding - pop) < FIFO_DEPTH`. `pop = valid_out && en`.
- `imem_req` is asserted while the issue condition holds, with `imem_addr = fetch_pc`. On `imem_gnt`: `outstanding`←1, the request PC is latched as the response tag, `fetch_pc += 4` (mod 2^PC_WIDTH; wrap from 0xFFFFFFFC to 0).
- On `imem_rvalid` with `drop`=0: push `{imem_rdata, tag}` and set `outstanding`←0 unless regranted the same cycle.
- On `imem_rvalid` with `drop`=1: discard the data and clear `drop`.
- On `redirect` (highest priority after `rst`):
  - queue flushed (`count`←0); pop ignored.
  - `fetch_pc`←`redirect_pc`.
  - `imem_req` held low this cycle.
  - If a granted request is outstanding and its response is not arriving this cycle: `drop`←1. A response arriving in the redirect cycle is discarded.
- While `drop`=1 no new request issues (`drop_blocking`). The first post-redirect request goes out the cycle after the stale response returns.
- `pc_plus4_out = pc_out + 4`, wrapping.
- `redirect_pc[1:0]` is ignored (forced to 0).

## Timing
- Reset values: `fetch_pc`=RESET_PC, `outstanding`=0, `drop`=0, `count`=0, `imem_req`=0, `valid_out`=0, `ins_out`=NOP, `pc_out`=0, `pc_plus4_out`=0.
- First request is issued in the first cycle after `rst` deasserts.
- Reset mid-operation: all state is cleared; an in-flight response after reset is ignored (`outstanding`=0 means no push).
- Latency without bypass: a response at edge t is visible on `valid_out` after edge t+1.
- With a 1-cycle memory and constant grant, throughput is 1 instruction/cycle in steady state.
- Queue full with `en`=0: `imem_req`=0; outputs held stable.
- Pop and push in the same cycle: `count` unchanged; outputs advance to the next entry.

## Configuration
- `IF_FETCH_BYPASS_EN` defined: when the queue is empty and an undropped `imem_rvalid` arrives, the response drives `valid_out`/`ins_out`/`pc_out` combinationally in the same cycle. If `en`=1 it is consumed without being pushed. Redirect-cycle responses are never bypassed.
- Undefined: all responses pass through the queue; minimum latency is one extra cycle.

## Test plan
- Reset, RESET_PC=0, memory grants and responds in 1 cycle, `en`=1 -> `pc_out` sequence 0,4,8,… one per cycle after fill; `pc_plus4_out` = `pc_out`+4.
- Hold `en`=0 for 5 cycles -> `count`=2, `imem_req`=0, outputs frozen at PC 0x8. Release -> 0x8, 0xC, 0x10 with no loss or duplication.
- Grant 0x10, assert `redirect` to 0x200 before the 3-cycle-late response -> stale 0x10 data dropped, next request addr 0x200, first valid `pc_out`=0x200.
- `redirect` in the same cycle as pop and an arriving response -> queue empty next cycle, nothing pushed, `imem_addr`=redirect target.
- `fetch_pc`=0xFFFFFFFC -> next request addr 0x0; `pc_plus4_out`=0x0 for that entry.
- Bypass build, empty queue, response 0x00500093 at PC 0x40 with `en`=1 -> `valid_out`=1 and `ins_out`=0x00500093 in the same cycle, `count` stays 0. Non-bypass build -> visible one cycle later.
